// File: rtl/decode_pkg.sv
// RV32 decode definitions: opcode constants, immediate-format enum, decoded-field bundle.
// Shared by imm_gen and decode_stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } imm_fmt_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
    imm_fmt_t   imm_fmt;
    logic       illegal;
  } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32 immediate generator: instr -> sign-extended imm, format, illegal flag.
// Zero latency, no flow control.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        imm_fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    imm_fmt = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm_fmt = FMT_I;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        imm_fmt = FMT_S;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        imm_fmt = FMT_B;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_fmt = FMT_U;
        imm32   = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        imm_fmt = FMT_J;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_REG: imm_fmt = FMT_R;
      // Every recognised opcode ends in 2'b11, so compressed encodings land here too.
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32 decode stage with optional 2-entry skid buffer between fetch and execute.
// Latency 1 cycle; SKID_EN=1 decouples in_ready from out_ready, SKID_EN=0 passes out_ready through.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        imm_fmt,
  output logic            illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state, state_nxt;
  logic            in_fire, out_fire;
  logic            load_out, load_skid, out_from_skid;
  decoded_t        in_dec, out_dec, skid_dec;
  logic [XLEN-1:0] in_imm, out_imm, skid_imm;
  logic [XLEN-1:0] out_pc_q, skid_pc;
  imm_fmt_t        in_fmt;
  logic            in_illegal;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .imm     (in_imm),
    .imm_fmt (in_fmt),
    .illegal (in_illegal)
  );

  // Decode happens before storage, so the skid entry already holds a finished bundle.
  assign in_dec = '{funct7:  in_instr[31:25],
                    rs2:     in_instr[24:20],
                    rs1:     in_instr[19:15],
                    funct3:  in_instr[14:12],
                    rd:      in_instr[11:7],
                    opcode:  in_instr[6:0],
                    imm_fmt: in_fmt,
                    illegal: in_illegal};

  assign out_valid = (state != EMPTY);
  assign in_ready  = !reset && (SKID_EN ? (state != TWO) : ((state == EMPTY) || out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_nxt     = ONE;
        load_out      = 1'b1;
        out_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // A same-cycle output transfer still completes; anything accepted this cycle is dropped.
    if (flush) begin
      state_nxt     = EMPTY;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      out_dec  <= '0;
      out_imm  <= '0;
      out_pc_q <= '0;
      skid_dec <= '0;
      skid_imm <= '0;
      skid_pc  <= '0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        if (out_from_skid) begin
          out_dec  <= skid_dec;
          out_imm  <= skid_imm;
          out_pc_q <= skid_pc;
        end else begin
          out_dec  <= in_dec;
          out_imm  <= in_imm;
          out_pc_q <= in_pc;
        end
      end
      if (load_skid) begin
        skid_dec <= in_dec;
        skid_imm <= in_imm;
        skid_pc  <= in_pc;
      end
    end
  end

  assign out_pc  = out_pc_q;
  assign opcode  = out_dec.opcode;
  assign rd      = out_dec.rd;
  assign funct3  = out_dec.funct3;
  assign rs1     = out_dec.rs1;
  assign rs2     = out_dec.rs2;
  assign funct7  = out_dec.funct7;
  assign imm     = out_imm;
  assign imm_fmt = out_dec.imm_fmt;
  assign illegal = out_dec.illegal;

endmodule
